// File: rtl/data_mem_lsu.sv
// data_mem_lsu: handshaked data memory for the RISC-V MEM stage.
//
// Request/response handshake: a request is taken on a rising edge where
// req_valid & req_ready; req_* are ignored whenever req_ready is low. The
// response is a single-cycle rsp_valid strobe with no back-pressure.
// rsp_rdata/rsp_err stay stable until the next response or reset.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_we                1 = store, 0 = load
//   req_addr              byte address (bits above ADDR_W-1 ignored)
//   req_wdata             right-aligned store data
//   req_funct3            RISC-V load/store funct3
//   rsp_valid             one-cycle response strobe
//   rsp_rdata             extended load data (0 for stores/errors)
//   rsp_err               misaligned or illegal funct3
//   dbg_state             current FSM state (0 IDLE, 1 WAIT, 2 RESP)
module data_mem_lsu #(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);
    localparam int WORDS  = 2 ** (ADDR_W - 2);
    localparam int WIDX_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               capture, enter_resp;

    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [2:0]         f3_q;

    // Word-organised storage; zero at time 0, never cleared by reset.
    logic [31:0]        mem [WORDS] = '{default: 32'h0};

    logic               cur_we;
    logic [ADDR_W-1:0]  cur_addr;
    logic [31:0]        cur_wdata;
    logic [2:0]         cur_f3;
    logic [1:0]         lane;
    logic [WIDX_W-1:0]  widx;
    logic               acc_err;
    logic [3:0]         be;
    logic [31:0]        wd, rword, ld_data;
    logic [7:0]         rbyte;
    logic [15:0]        rhalf;

    logic               unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W];

    // With LATENCY==1 the response edge is also the accept edge, so the
    // access must be decoded from the live request rather than the captured copy.
    assign cur_we    = (state_q == IDLE) ? req_we               : we_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr[ADDR_W-1:0] : addr_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata            : wdata_q;
    assign cur_f3    = (state_q == IDLE) ? req_funct3           : f3_q;
    assign lane      = cur_addr[1:0];

    generate
        if (ADDR_W > 2) begin : g_widx
            assign widx = cur_addr[ADDR_W-1:2];
        end else begin : g_widx_one
            assign widx = '0;
        end
    endgenerate

    // FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        enter_resp = (state_d == RESP) && (state_q != RESP);
    end

    // Error decode and store byte-lane steering
    always_comb begin
        acc_err = 1'b0;
        be      = 4'b0000;
        wd      = 32'h0;
        if (cur_we) begin
            case (cur_f3)
                3'b000: begin
                    be = 4'b0001 << lane;
                    wd = {4{cur_wdata[7:0]}};
                end
                3'b001: begin
                    acc_err = lane[0];
                    be      = lane[1] ? 4'b1100 : 4'b0011;
                    wd      = {2{cur_wdata[15:0]}};
                end
                3'b010: begin
                    acc_err = (lane != 2'b00);
                    be      = 4'b1111;
                    wd      = cur_wdata;
                end
                default: acc_err = 1'b1;
            endcase
        end else begin
            case (cur_f3)
                3'b000, 3'b100: acc_err = 1'b0;
                3'b001, 3'b101: acc_err = lane[0];
                3'b010:         acc_err = (lane != 2'b00);
                default:        acc_err = 1'b1;
            endcase
        end
        if (acc_err) be = 4'b0000;
    end

    // Load extraction and extension
    always_comb begin
        rword = mem[widx];
        case (lane)
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        rhalf = lane[1] ? rword[31:16] : rword[15:0];
        case (cur_f3)
            3'b000:  ld_data = {{24{rbyte[7]}}, rbyte};
            3'b100:  ld_data = {24'h0, rbyte};
            3'b001:  ld_data = {{16{rhalf[15]}}, rhalf};
            3'b101:  ld_data = {16'h0, rhalf};
            3'b010:  ld_data = rword;
            default: ld_data = 32'h0;
        endcase
        if (cur_we || acc_err) ld_data = 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            f3_q      <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                we_q    <= req_we;
                addr_q  <= req_addr[ADDR_W-1:0];
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
            end
            if (enter_resp) begin
                rsp_rdata <= ld_data;
                rsp_err   <= acc_err;
            end
        end
    end

    // Store commit on the edge entering RESP; a reset on that edge abandons it.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    assign req_ready = (state_q == IDLE) && rst_n;
    assign rsp_valid = (state_q == RESP);
    assign dbg_state = state_q;

endmodule
